// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount datapath.
// Used by both the popcounter instantiation site and the frame accumulator.
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DROP} acc_state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned sum_w(input int unsigned width, input int unsigned max_words);
    return $clog2(width * max_words + 1);
  endfunction

  function automatic int unsigned len_w(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/popcount_result_reg.sv
// Single-entry valid/ready output register.
// A load wins over a drain in the same cycle, so simultaneous drain+load keeps o_valid high.
module popcount_result_reg #(
  parameter int unsigned DataW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [DataW-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_ready,
  output logic [DataW-1:0] o_data
);

  logic             valid_q;
  logic [DataW-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      data_q  <= i_data;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_ready = ~valid_q | i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Sums per-word popcounts over a frame delimited by i_last and emits one registered
// result per frame (total, word count, overflow) over a valid/ready stream.
module popcount_frame_accumulator
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_WORDS = 256,
  localparam int unsigned CNT_W    = cnt_w(WIDTH),
  localparam int unsigned SUM_W    = sum_w(WIDTH, MAX_WORDS),
  localparam int unsigned LEN_W    = len_w(MAX_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [SUM_W-1:0] o_sum,
  output logic [LEN_W-1:0] o_words,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int unsigned PAY_W = SUM_W + LEN_W + 1;

  acc_state_e       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] words_q, words_d;

  logic             accept;
  logic             full;
  logic [SUM_W-1:0] acc_sum;
  logic [LEN_W-1:0] words_inc;

  logic             res_load;
  logic [SUM_W-1:0] res_sum;
  logic [LEN_W-1:0] res_words;
  logic             res_ovf;
  logic [PAY_W-1:0] res_out;

  assign accept    = i_valid & o_ready;
  assign full      = (words_q == LEN_W'(MAX_WORDS));
  assign acc_sum   = acc_q + SUM_W'(i_count);
  assign words_inc = words_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    words_d   = words_q;
    res_load  = 1'b0;
    res_sum   = acc_q;
    res_words = words_q;
    res_ovf   = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if ((state_q == ACCUM) && full) begin
            // Frame is already at capacity: discard this count.
            if (i_last) begin
              res_load = 1'b1;
              res_ovf  = 1'b1;
              acc_d    = '0;
              words_d  = '0;
              state_d  = IDLE;
            end else begin
              state_d = DROP;
            end
          end else if (i_last) begin
            res_load  = 1'b1;
            res_sum   = acc_sum;
            res_words = words_inc;
            acc_d     = '0;
            words_d   = '0;
            state_d   = IDLE;
          end else begin
            acc_d   = acc_sum;
            words_d = words_inc;
            state_d = ACCUM;
          end
        end
        DROP: begin
          if (i_last) begin
            res_load = 1'b1;
            res_ovf  = 1'b1;
            acc_d    = '0;
            words_d  = '0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      words_q <= words_d;
    end
  end

  assign o_busy = (state_q != IDLE);

  popcount_result_reg #(
    .DataW (PAY_W)
  ) u_result_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (res_load),
    .i_data  ({res_sum, res_words, res_ovf}),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (res_out)
  );

  assign {o_sum, o_words, o_overflow} = res_out;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Bench for popcount_frame_accumulator: two instances (MAX_WORDS 256 and 4) share stimulus,
// each with its own reference model and result queue.
module tb_popcount_frame_accumulator;
  import popcount_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned MW  = 256;
  localparam int unsigned MW4 = 4;
  localparam int unsigned CW  = cnt_w(W);
  localparam int unsigned SW  = sum_w(W, MW);
  localparam int unsigned LW  = len_w(MW);
  localparam int unsigned SW4 = sum_w(W, MW4);
  localparam int unsigned LW4 = len_w(MW4);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic          rdy_in = 1'b1;
  logic [CW-1:0] count = '0;

  logic           ready, ovalid, ovf, busy;
  logic [SW-1:0]  sum;
  logic [LW-1:0]  words;
  logic           ready4, ovalid4, ovf4, busy4;
  logic [SW4-1:0] sum4;
  logic [LW4-1:0] words4;

  typedef struct {
    int unsigned sum;
    int unsigned words;
    bit          ovf;
  } res_t;

  res_t q_big[$];
  res_t q_small[$];

  int unsigned mb_acc = 0, mb_words = 0, ms_acc = 0, ms_words = 0;
  bit          mb_ovf = 0, ms_ovf = 0;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  popcount_frame_accumulator #(
    .WIDTH     (W),
    .MAX_WORDS (MW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_count    (count),
    .i_last     (last),
    .o_valid    (ovalid),
    .i_ready    (rdy_in),
    .o_sum      (sum),
    .o_words    (words),
    .o_overflow (ovf),
    .o_busy     (busy)
  );

  popcount_frame_accumulator #(
    .WIDTH     (W),
    .MAX_WORDS (MW4)
  ) dut4 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .o_ready    (ready4),
    .i_count    (count),
    .i_last     (last),
    .o_valid    (ovalid4),
    .i_ready    (rdy_in),
    .o_sum      (sum4),
    .o_words    (words4),
    .o_overflow (ovf4),
    .o_busy     (busy4)
  );

  always @(negedge clk) begin
    if (valid) assert (count <= W) else $error("i_count above WIDTH");
  end

  // Scoreboard: a result is consumed when o_valid & i_ready are seen before the edge.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1) begin
      if (ovalid === 1'b1 && rdy_in === 1'b1) begin
        n_checks++;
        if (q_big.size() == 0) begin
          $display("FAIL result_big unexpected got sum=%0d words=%0d ovf=%0b required none",
                   sum, words, ovf);
        end else begin
          e = q_big.pop_front();
          if (sum !== SW'(e.sum) || words !== LW'(e.words) || ovf !== e.ovf)
            $display("FAIL result_big got sum=%0d words=%0d ovf=%0b required sum=%0d words=%0d ovf=%0b",
                     sum, words, ovf, e.sum, e.words, e.ovf);
          else n_pass++;
        end
      end
      if (ovalid4 === 1'b1 && rdy_in === 1'b1) begin
        n_checks++;
        if (q_small.size() == 0) begin
          $display("FAIL result_small unexpected got sum=%0d words=%0d ovf=%0b required none",
                   sum4, words4, ovf4);
        end else begin
          e = q_small.pop_front();
          if (sum4 !== SW4'(e.sum) || words4 !== LW4'(e.words) || ovf4 !== e.ovf)
            $display("FAIL result_small got sum=%0d words=%0d ovf=%0b required sum=%0d words=%0d ovf=%0b",
                     sum4, words4, ovf4, e.sum, e.words, e.ovf);
          else n_pass++;
        end
      end
    end
  end

  task automatic model_beat(input int unsigned c, input bit l);
    res_t r;
    if (mb_words < MW) begin mb_acc += c; mb_words++; end else mb_ovf = 1'b1;
    if (ms_words < MW4) begin ms_acc += c; ms_words++; end else ms_ovf = 1'b1;
    if (l) begin
      r.sum = mb_acc; r.words = mb_words; r.ovf = mb_ovf;
      q_big.push_back(r);
      r.sum = ms_acc; r.words = ms_words; r.ovf = ms_ovf;
      q_small.push_back(r);
      mb_acc = 0; mb_words = 0; mb_ovf = 1'b0;
      ms_acc = 0; ms_words = 0; ms_ovf = 1'b0;
    end
  endtask

  task automatic model_clear();
    mb_acc = 0; mb_words = 0; mb_ovf = 1'b0;
    ms_acc = 0; ms_words = 0; ms_ovf = 1'b0;
    q_big.delete();
    q_small.delete();
  endtask

  // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send_beat(input int unsigned c, input bit l);
    int  n = 0;
    bit  ok = 1'b0;
    valid = 1'b1;
    count = CW'(c);
    last  = l;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ready === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout got ready=%b required 1", ready);
    end else begin
      model_beat(c, l);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    last  = 1'b0;
    count = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ovalid !== 1'b0) $display("FAIL rst_o_valid got=%b required=0", ovalid); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL rst_o_sum got=%0d required=0", sum); else n_pass++;
    n_checks++; if (words !== '0) $display("FAIL rst_o_words got=%0d required=0", words); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_o_overflow got=%b required=0", ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_o_busy got=%b required=0", busy); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rst_o_ready got=%b required=1", ready); else n_pass++;
    n_checks++; if (ovalid4 !== 1'b0 || busy4 !== 1'b0) $display("FAIL rst_small got valid=%b busy=%b required 0 0", ovalid4, busy4); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    rdy_in = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_before got=%b required=0", busy); else n_pass++;
    send_beat(5, 1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_mid1 got=%b required=1", busy); else n_pass++;
    send_beat(32, 1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_mid2 got=%b required=1", busy); else n_pass++;
    send_beat(0, 1'b1);
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b required=0", busy); else n_pass++;
    n_checks++; if (ovalid !== 1'b1) $display("FAIL basic_latency got o_valid=%b required=1", ovalid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ovalid !== 1'b0) $display("FAIL basic_drained got o_valid=%b required=0", ovalid); else n_pass++;
  endtask

  task automatic test_single_beat();
    send_beat(17, 1'b1);
    n_checks++; if (ovalid !== 1'b1) $display("FAIL single_valid got=%b required=1", ovalid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ovalid !== 1'b0) $display("FAIL single_next got o_valid=%b required=0", ovalid); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) send_beat(10, 1'b0);
    n_checks++; if (dut4.state_q !== DROP) $display("FAIL ovf_state_small got=%0d required=%0d", dut4.state_q, DROP); else n_pass++;
    n_checks++; if (dut.state_q !== ACCUM) $display("FAIL ovf_state_big got=%0d required=%0d", dut.state_q, ACCUM); else n_pass++;
    send_beat(10, 1'b1);
    n_checks++; if (ovf4 !== 1'b1 || ovf !== 1'b0) $display("FAIL ovf_flags got small=%b big=%b required 1 0", ovf4, ovf); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned vals[3] = '{3, 7, 9};
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(vals[i], 1'b1);
      n_checks++; if (ovalid !== 1'b1) $display("FAIL b2b_valid_%0d got=%b required=1", i, ovalid); else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++; if (ovalid !== 1'b0) $display("FAIL b2b_end got o_valid=%b required=0", ovalid); else n_pass++;
  endtask

  task automatic test_backpressure();
    rdy_in = 1'b0;
    send_beat(6, 1'b1);
    valid = 1'b1;
    count = CW'(2);
    last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (ready !== 1'b0) $display("FAIL bp_ready_%0d got=%b required=0", i, ready); else n_pass++;
      n_checks++; if (ovalid !== 1'b1 || sum !== SW'(6) || words !== LW'(1))
        $display("FAIL bp_hold_%0d got valid=%b sum=%0d words=%0d required 1 6 1", i, ovalid, sum, words);
      else n_pass++;
    end
    @(posedge clk); #1;
    rdy_in = 1'b1;
    send_beat(2, 1'b1);
    n_checks++; if (ovalid !== 1'b1 || sum !== SW'(2)) $display("FAIL bp_new got valid=%b sum=%0d required 1 2", ovalid, sum); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b required=0", busy); else n_pass++;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (q_big.size() != 0 || q_small.size() != 0)
      $display("FAIL pending_results got big=%0d small=%0d required 0 0", q_big.size(), q_small.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
